// File: rtl/des_pkg.sv
// DES key schedule shared definitions: permutation tables (FIPS bit numbering),
// FSM states, 28-bit half rotations and the default per-round shift schedule.
package des_pkg;

    localparam logic [15:0] SHIFT_SCHED_DEFAULT = 16'h7EFC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entry j holds the key bit (1 = MSB) that lands in output bit j+1.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic by2);
        return by2 ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic by2);
        return by2 ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC2 compression: selects 48 of the 56 C/D bits to form one round subkey.
// Latency: combinational. Backpressure: none (pure function of cd_i).
// Purely combinational; no state.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);

    for (genvar j = 0; j < 48; j++) begin : g_sel
        assign subkey_o[47-j] = cd_i[56-PC2_TAB[j]];
    end

    // CD bits 9,18,22,25,35,38,43,54 are dropped by PC2.
    logic unused_cd;
    assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                         cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one key in, 16 subkeys out (K1..K16 or K16..K1).
// Latency: first subkey 1 cycle after key accept, then one per handshake.
// Backpressure: sk_ready low holds the subkey; key_ready is high only when idle.
// Optional weak-key detection is enabled with `define DES_WEAK_KEY_DET_EN.
module des_key_schedule
    import des_pkg::*;
#(
    parameter logic [15:0] SHIFT_SCHED = SHIFT_SCHED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic [3:0]  sk_round,
    output logic        sk_valid,
    output logic        sk_last,
    input  logic        sk_ready,
    output logic        weak_key
);

    logic [55:0] pc1_key;
    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign pc1_key[55-j] = key[64-PC1_TAB[j]];
    end

    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    state_e      state_q;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [3:0]  cnt_q;
    logic        dir_q;
    logic        key_ready_q, sk_valid_q, sk_last_q;
    logic [3:0]  sk_round_q;
    logic        accept, handshake, advance;

    assign accept    = key_valid && key_ready_q;
    assign handshake = sk_valid_q && sk_ready;
    assign advance   = handshake && (cnt_q != 4'd15);

    // Decrypt starts from CD0 (== CD16) and walks backwards with right rotations.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (accept) begin
            if (decrypt) begin
                c_d = pc1_key[55:28];
                d_d = pc1_key[27:0];
            end else begin
                c_d = rotl28(pc1_key[55:28], SHIFT_SCHED[0]);
                d_d = rotl28(pc1_key[27:0],  SHIFT_SCHED[0]);
            end
        end else if (advance) begin
            if (dir_q) begin
                c_d = rotr28(c_q, SHIFT_SCHED[~cnt_q]);
                d_d = rotr28(d_q, SHIFT_SCHED[~cnt_q]);
            end else begin
                c_d = rotl28(c_q, SHIFT_SCHED[cnt_q + 4'd1]);
                d_d = rotl28(d_q, SHIFT_SCHED[cnt_q + 4'd1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            key_ready_q <= 1'b1;
            sk_valid_q  <= 1'b0;
            sk_last_q   <= 1'b0;
            sk_round_q  <= '0;
        end else begin
            c_q <= c_d;
            d_q <= d_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= RUN;
                        key_ready_q <= 1'b0;
                        sk_valid_q  <= 1'b1;
                        sk_last_q   <= 1'b0;
                        cnt_q       <= '0;
                        dir_q       <= decrypt;
                        sk_round_q  <= decrypt ? 4'd15 : 4'd0;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (sk_last_q) begin
                            state_q     <= IDLE;
                            key_ready_q <= 1'b1;
                            sk_valid_q  <= 1'b0;
                            sk_last_q   <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + 4'd1;
                            sk_last_q  <= (cnt_q == 4'd14);
                            sk_round_q <= dir_q ? sk_round_q - 4'd1 : sk_round_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey)
    );

    assign key_ready = key_ready_q;
    assign sk_valid  = sk_valid_q;
    assign sk_last   = sk_last_q;
    assign sk_round  = sk_round_q;

`ifdef DES_WEAK_KEY_DET_EN
    logic weak_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weak_q <= 1'b0;
        end else if (accept) begin
            weak_q <= ((&pc1_key[55:28]) || (~|pc1_key[55:28])) &&
                      ((&pc1_key[27:0])  || (~|pc1_key[27:0]));
        end
    end
    assign weak_key = weak_q;
`else
    assign weak_key = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: known-answer vectors, random keys with
// random backpressure against an array-based FIPS 46-3 key schedule model.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] key;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  sk_round;
    logic        sk_valid;
    logic        sk_last;
    logic        sk_ready;
    logic        weak_key;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .decrypt   (decrypt),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .subkey    (subkey),
        .sk_round  (sk_round),
        .sk_valid  (sk_valid),
        .sk_last   (sk_last),
        .sk_ready  (sk_ready),
        .weak_key  (weak_key)
    );

    localparam int TPC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TPC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int TSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [47:0] exp_sk [16];
    logic        exp_weak;
    logic [47:0] got_first, got_last;
    logic [3:0]  got_first_round, got_last_round;

    // Kn = PC2 of the halves rotated left by the cumulative shift total of rounds 1..n.
    task automatic compute_model(input logic [63:0] k);
        bit          kb [1:64];
        bit          c0 [1:28];
        bit          d0 [1:28];
        bit          cd [1:56];
        logic [63:0] t;
        logic [47:0] s;
        int          sh;
        bit          c_same, d_same;
        t = k;
        for (int i = 1; i <= 64; i++) begin
            kb[i] = t[63];
            t = t << 1;
        end
        for (int i = 1; i <= 28; i++) begin
            c0[i] = kb[TPC1[i-1]];
            d0[i] = kb[TPC1[i+27]];
        end
        sh = 0;
        for (int n = 0; n < 16; n++) begin
            sh += TSHIFT[n];
            for (int i = 1; i <= 28; i++) begin
                cd[i]    = c0[((i - 1 + sh) % 28) + 1];
                cd[i+28] = d0[((i - 1 + sh) % 28) + 1];
            end
            s = '0;
            for (int j = 0; j < 48; j++) s = {s[46:0], cd[TPC2[j]]};
            exp_sk[n] = s;
        end
        c_same = 1'b1;
        d_same = 1'b1;
        for (int i = 2; i <= 28; i++) begin
            if (c0[i] != c0[1]) c_same = 1'b0;
            if (d0[i] != d0[1]) d_same = 1'b0;
        end
`ifdef DES_WEAK_KEY_DET_EN
        exp_weak = c_same && d_same;
`else
        exp_weak = 1'b0;
`endif
    endtask

    task automatic accept_key(input logic [63:0] k, input logic dec, input bit rnd);
        compute_model(k);
        @(posedge clk); #1;
        key = k; decrypt = dec; key_valid = 1'b1;
        sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        n_cmp++;
        if (key_ready !== 1'b1) begin
            n_err++; $display("FAIL key_ready_idle: got %b want 1", key_ready);
        end
        @(posedge clk); #1;
        key_valid = 1'b0; decrypt = ~dec; key = {$urandom, $urandom};
        n_cmp++;
        if (weak_key !== exp_weak) begin
            n_err++; $display("FAIL weak_key: got %b want %b", weak_key, exp_weak);
        end
    endtask

    task automatic drain(input logic dec, input bit rnd, input int max_hs);
        int          hs = 0;
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [47:0] p_sk;
        logic [3:0]  p_rnd;
        logic        p_last;
        int          er;
        while (hs < max_hs && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_cmp++;
                if (sk_valid !== 1'b1) begin
                    n_err++; $display("FAIL first_latency: sk_valid got %b want 1", sk_valid);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (subkey !== p_sk || sk_round !== p_rnd || sk_last !== p_last || sk_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h/%0d/%b want %h/%0d/%b",
                             subkey, sk_round, sk_last, p_sk, p_rnd, p_last);
                end
            end
            if (sk_valid === 1'b1 && sk_ready === 1'b1) begin
                er = dec ? 15 - hs : hs;
                n_cmp++;
                if (subkey !== exp_sk[er] || sk_round !== 4'(er) || sk_last !== (hs == 15) ||
                    key_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL subkey_hs%0d: got sk=%h rnd=%0d last=%b krdy=%b want sk=%h rnd=%0d last=%b krdy=0",
                             hs, subkey, sk_round, sk_last, key_ready, exp_sk[er], er, (hs == 15));
                end
                if (hs == 0)  begin got_first = subkey; got_first_round = sk_round; end
                if (hs == 15) begin got_last  = subkey; got_last_round  = sk_round; end
                hs++;
            end
            prev_stall = (sk_valid === 1'b1) && (sk_ready !== 1'b1);
            p_sk = subkey; p_rnd = sk_round; p_last = sk_last;
            cyc++;
            @(posedge clk); #1;
            sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (hs < max_hs) begin
            n_err++; $display("FAIL stream_timeout: got %0d handshakes want %0d", hs, max_hs);
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        n_cmp++;
        if (key_ready !== 1'b1 || sk_valid !== 1'b0 || sk_last !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_last: krdy=%b vld=%b last=%b want 1/0/0", key_ready, sk_valid, sk_last);
        end
    endtask

    task automatic run_stream(input logic [63:0] k, input logic dec, input bit rnd);
        accept_key(k, dec, rnd);
        drain(dec, rnd, 16);
        check_idle_after();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key = '0; decrypt = 1'b0; key_valid = 1'b0; sk_ready = 1'b0;
        #12;
        n_cmp++;
        if (key_ready !== 1'b1 || sk_valid !== 1'b0 || sk_last !== 1'b0 || subkey !== 48'h0 ||
            sk_round !== 4'd0 || weak_key !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: krdy=%b vld=%b last=%b sk=%h rnd=%0d weak=%b", key_ready,
                     sk_valid, sk_last, subkey, sk_round, weak_key);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt();
        run_stream(64'h133457799BBCDFF1, 1'b0, 1'b0);
        n_cmp++;
        if (got_first !== 48'h1B02EFFC7072 || got_first_round !== 4'd0) begin
            n_err++; $display("FAIL enc_first: got %h/%0d want 1b02effc7072/0", got_first, got_first_round);
        end
        n_cmp++;
        if (got_last !== 48'hCB3D8B0E17F5 || got_last_round !== 4'd15) begin
            n_err++; $display("FAIL enc_last: got %h/%0d want cb3d8b0e17f5/15", got_last, got_last_round);
        end
    endtask

    task automatic test_decrypt();
        run_stream(64'h133457799BBCDFF1, 1'b1, 1'b0);
        n_cmp++;
        if (got_first !== 48'hCB3D8B0E17F5 || got_first_round !== 4'd15) begin
            n_err++; $display("FAIL dec_first: got %h/%0d want cb3d8b0e17f5/15", got_first, got_first_round);
        end
        n_cmp++;
        if (got_last !== 48'h1B02EFFC7072 || got_last_round !== 4'd0) begin
            n_err++; $display("FAIL dec_last: got %h/%0d want 1b02effc7072/0", got_last, got_last_round);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) begin
            run_stream({$urandom, $urandom}, 1'(i % 2), 1'b1);
        end
    endtask

    task automatic test_reset_midstream();
        accept_key({$urandom, $urandom}, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sk_valid !== 1'b0 || key_ready !== 1'b1 || sk_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: vld=%b krdy=%b last=%b want 0/1/0", sk_valid, key_ready, sk_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sk_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_no_more: sk_valid got %b want 0", sk_valid);
            end
        end
        run_stream({$urandom, $urandom}, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] k2;
        k2 = {$urandom, $urandom};
        accept_key({$urandom, $urandom}, 1'b0, 1'b0);
        key = k2; decrypt = 1'b0; key_valid = 1'b1;
        drain(1'b0, 1'b0, 16);
        @(negedge clk);
        n_cmp++;
        if (key_ready !== 1'b1 || sk_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle: krdy=%b vld=%b want 1/0", key_ready, sk_valid);
        end
        compute_model(k2);
        @(posedge clk); #1;
        key_valid = 1'b0;
        drain(1'b0, 1'b0, 16);
        check_idle_after();
    endtask

    task automatic test_weak();
        run_stream(64'h0101010101010101, 1'b0, 1'b1);
        n_cmp++;
        if (got_first !== 48'h0 || got_last !== 48'h0) begin
            n_err++; $display("FAIL weak_subkeys: got %h/%h want 0/0", got_first, got_last);
        end
        accept_key(64'h133457799BBCDFF1, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 16);
        n_cmp++;
        if (weak_key !== 1'b0) begin
            n_err++; $display("FAIL weak_clear: got %b want 0", weak_key);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        test_weak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
